// File: rtl/round_off_param_if.sv
// Request/result bundle for the rounding stage between the alignment shifter and the packer.
interface round_off_param_if #(
  parameter int unsigned IN_W  = 64,
  parameter int unsigned OUT_W = 32,
  parameter int unsigned K_W   = 6,
  parameter int unsigned NBT_W = $clog2(OUT_W + 1)
);
  logic             start;
  logic [1:0]       mode;
  logic [IN_W-1:0]  shifted_mantissa;
  logic [K_W-1:0]   k_in;
  logic             busy;
  logic             done;
  logic [OUT_W-1:0] mantissa_out;
  logic [NBT_W-1:0] nbt_out;
  logic             inexact;
  logic             carry_out;
  logic             sat;

  modport master (
    output start, mode, shifted_mantissa, k_in,
    input  busy, done, mantissa_out, nbt_out, inexact, carry_out, sat
  );

  modport slave (
    input  start, mode, shifted_mantissa, k_in,
    output busy, done, mantissa_out, nbt_out, inexact, carry_out, sat
  );
endinterface

// File: rtl/round_off_param.sv
// Extracts an OUT_W-bit field from an aligned mantissa, keeps the top nbt bits (set by k)
// and rounds to that width in one of four modes. Three-step sequencer, one op per 4 cycles.
module round_off_param #(
  parameter int unsigned IN_W      = 64,
  parameter int unsigned OUT_W     = 32,
  parameter int unsigned K_W       = 6,
  parameter int unsigned MSB_POS   = 61,
  parameter int unsigned BASE_BITS = 26,
  parameter int unsigned NBT_W     = $clog2(OUT_W + 1)
) (
  input logic              clk,
  input logic              rst,
  round_off_param_if.slave bus
);

  localparam int unsigned RAW_W = K_W + 2;
  localparam int unsigned POS_W = $clog2(IN_W);

  typedef enum logic [1:0] {StIdle, StAlign, StRound, StDone} state_e;

  state_e state_q, state_d;

  // Operation latched at accept time
  logic [IN_W-1:0]  mant_q;
  logic [K_W-1:0]   k_q;
  logic [1:0]       mode_q;

  // Alignment results
  logic [NBT_W-1:0] nbt_q;
  logic [OUT_W-1:0] mask_q;
  logic             guard_q;
  logic             sticky_q;
  logic             sat_q;

  // Result registers, held until the next completed op
  logic [OUT_W-1:0] mant_out_q;
  logic [NBT_W-1:0] nbt_out_q;
  logic             inexact_q;
  logic             carry_q;
  logic             sat_out_q;

  // ---------------------------------------------------------------------------
  // Sequencer
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (bus.start) state_d = StAlign;
      StAlign: state_d = StRound;
      StRound: state_d = StDone;
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Alignment: kept-bit count, mask, guard and sticky
  // ---------------------------------------------------------------------------
  logic signed [RAW_W-1:0] k_ext;
  logic signed [RAW_W-1:0] raw_nbt;
  logic [NBT_W-1:0]        nbt_d;
  logic                    sat_d;
  logic [POS_W-1:0]        gpos;
  logic [IN_W-1:0]         below_mask;
  logic [OUT_W-1:0]        mask_d;
  logic                    guard_d;
  logic                    sticky_d;

  always_comb begin
    k_ext   = $signed({{2{k_q[K_W-1]}}, k_q});
    raw_nbt = '0;
    nbt_d   = '0;
    sat_d   = 1'b0;
    // Negative k keeps one extra bit relative to the positive branch
    if (k_q[K_W-1]) begin
      raw_nbt = $signed(RAW_W'(BASE_BITS)) + $signed(RAW_W'(1)) + k_ext;
    end else begin
      raw_nbt = $signed(RAW_W'(BASE_BITS)) - k_ext;
    end
    if (raw_nbt[RAW_W-1]) begin
      nbt_d = '0;
      sat_d = 1'b1;
    end else if (raw_nbt > $signed(RAW_W'(OUT_W))) begin
      nbt_d = NBT_W'(OUT_W);
      sat_d = 1'b1;
    end else begin
      nbt_d = NBT_W'(raw_nbt);
    end
    // Guard sits one below the kept LSB; at nbt==OUT_W this falls just under the field
    gpos       = POS_W'(MSB_POS) - POS_W'(nbt_d);
    mask_d     = ~({OUT_W{1'b1}} >> nbt_d);
    guard_d    = mant_q[gpos];
    below_mask = (IN_W'(1) << gpos) - IN_W'(1);
    sticky_d   = |(mant_q & below_mask);
  end

  // ---------------------------------------------------------------------------
  // Rounding
  // ---------------------------------------------------------------------------
  logic [OUT_W-1:0] ext;
  logic [OUT_W-1:0] kept;
  logic [NBT_W-1:0] lsb_sh;
  logic [OUT_W:0]   weight;
  logic             kept_lsb;
  logic             incr;
  logic [OUT_W:0]   sum;

  always_comb begin
    ext    = mant_q[MSB_POS -: OUT_W];
    kept   = ext & mask_q;
    lsb_sh = NBT_W'(OUT_W) - nbt_q;
    // At nbt==0 the weight lands on bit OUT_W, so the kept LSB reads as 0 and any
    // increment shows up purely as carry
    weight   = (OUT_W + 1)'(1) << lsb_sh;
    kept_lsb = |(kept & weight[OUT_W-1:0]);
    incr     = 1'b0;
    unique case (mode_q)
      2'b00:   incr = 1'b0;
      2'b01:   incr = guard_q & (sticky_q | kept_lsb);
      2'b10:   incr = guard_q;
      2'b11:   incr = guard_q | sticky_q;
      default: incr = 1'b0;
    endcase
    sum = {1'b0, kept} + (incr ? weight : '0);
  end

  // ---------------------------------------------------------------------------
  // Datapath registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mant_q     <= '0;
      k_q        <= '0;
      mode_q     <= '0;
      nbt_q      <= '0;
      mask_q     <= '0;
      guard_q    <= 1'b0;
      sticky_q   <= 1'b0;
      sat_q      <= 1'b0;
      mant_out_q <= '0;
      nbt_out_q  <= '0;
      inexact_q  <= 1'b0;
      carry_q    <= 1'b0;
      sat_out_q  <= 1'b0;
    end else begin
      if (state_q == StIdle && bus.start) begin
        mant_q <= bus.shifted_mantissa;
        k_q    <= bus.k_in;
        mode_q <= bus.mode;
      end
      if (state_q == StAlign) begin
        nbt_q    <= nbt_d;
        mask_q   <= mask_d;
        guard_q  <= guard_d;
        sticky_q <= sticky_d;
        sat_q    <= sat_d;
      end
      if (state_q == StRound) begin
        mant_out_q <= sum[OUT_W-1:0] & mask_q;
        carry_q    <= sum[OUT_W];
        inexact_q  <= guard_q | sticky_q;
        nbt_out_q  <= nbt_q;
        sat_out_q  <= sat_q;
      end
    end
  end

  assign bus.busy         = (state_q != StIdle);
  assign bus.done         = (state_q == StDone);
  assign bus.mantissa_out = mant_out_q;
  assign bus.nbt_out      = nbt_out_q;
  assign bus.inexact      = inexact_q;
  assign bus.carry_out    = carry_q;
  assign bus.sat          = sat_out_q;

endmodule
